// File: rtl/riscv_multicycle_controller.sv
// riscv_multicycle_controller
// ---------------------------
// Control unit for a shared-memory multi-cycle RV32I datapath. Each
// instruction runs through a sequence of states. Memory accesses use a
// req/ready handshake and may take any number of cycles.
//
// Beyond basic sequencing, this block provides:
//   - a memory timeout that traps after MEM_TIMEOUT wait cycles
//     (setting MEM_TIMEOUT to 0 disables the timeout),
//   - a trap on illegal opcodes and illegal funct3 codes,
//   - free-running cycle and retired-instruction counters for debug.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   Instr               instruction register contents
//   Zero                ALU zero flag
//   mem_ready           memory finishes the current access this cycle
//   mem_req, mem_we     memory request, and write qualifier
//   AdrSrc              memory address select (0 = PC, 1 = ALUOut)
//   IRWrite, PCWrite    IR/OldPC load strobe, PC load strobe
//   RegWrite            register file write strobe
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ResultSrc           result bus select
//   ImmSrc              immediate format select
//   ALUControl          ALU operation
//   state_out           current state encoding, for debug
//   illegal, mem_fault  sticky trap flags
//   cycle_count         cycles since reset was released
//   instret_count       retired instructions

module riscv_multicycle_controller #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          Instr,
   input  logic                 Zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_we,
   output logic                 AdrSrc,
   output logic                 IRWrite,
   output logic                 PCWrite,
   output logic                 RegWrite,
   output logic [1:0]           ALUSrcA,
   output logic [1:0]           ALUSrcB,
   output logic [1:0]           ResultSrc,
   output logic [2:0]           ImmSrc,
   output logic [3:0]           ALUControl,
   output logic [3:0]           state_out,
   output logic                 illegal,
   output logic                 mem_fault,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] instret_count
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_LUI      = 4'd11,
      S_TRAP     = 4'd15
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_OR  = 4'b0011;
   localparam logic [3:0] ALU_XOR = 4'b0100;
   localparam logic [3:0] ALU_SLT = 4'b0101;
   localparam logic [3:0] ALU_SLL = 4'b0110;
   localparam logic [3:0] ALU_SRL = 4'b0111;
   localparam logic [3:0] ALU_SRA = 4'b1000;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // The wait counter only has to reach MEM_TIMEOUT-1. At that point, one
   // more cycle without ready is the timeout.
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam int TO_LAST = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TO_LAST);

   state_t            state, next_state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              set_illegal, set_fault, timeout_hit;
   logic              mem_req_s, mem_we_s, ir_write_s, pc_write_s, reg_write_s;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic              funct7b5;
   logic              unused_instr_bits;

   assign opcode   = Instr[6:0];
   assign funct3   = Instr[14:12];
   assign funct7b5 = Instr[30];
   assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

   // ALU operation for EXECR/EXECI. Only R-type honours funct7[5] on
   // funct3=000. For I-type, that bit belongs to the immediate.
   function automatic logic [3:0] alu_decode(input logic [2:0] f3,
                                             input logic       f7b5,
                                             input logic       rtype);
      logic [3:0] op;
      op = ALU_ADD;
      case (f3)
         3'b000:  op = (rtype && f7b5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b100:  op = ALU_XOR;
         3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         3'b111:  op = ALU_AND;
         default: op = ALU_ADD;
      endcase
      return op;
   endfunction

   // Timeout fires on the wait cycle that would take the counter to
   // MEM_TIMEOUT. A ready in that same cycle still completes the access.
   assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

   // Next-state logic. The trap flags are raised on the transition into TRAP.
   always_comb begin
      next_state  = state;
      set_illegal = 1'b0;
      set_fault   = 1'b0;
      case (state)
         S_FETCH, S_MEMREAD, S_MEMWRITE: begin
            if (mem_ready) begin
               case (state)
                  S_FETCH:   next_state = S_DECODE;
                  S_MEMREAD: next_state = S_MEMWB;
                  default:   next_state = S_FETCH;
               endcase
            end else if (timeout_hit) begin
               next_state = S_TRAP;
               set_fault  = 1'b1;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEMADR;
               OP_RTYPE:          next_state = S_EXECR;
               OP_ITYPE:          next_state = S_EXECI;
               OP_BRANCH:         next_state = S_BRANCH;
               OP_JAL:            next_state = S_JAL;
               OP_LUI:            next_state = S_LUI;
               default: begin
                  next_state  = S_TRAP;
                  set_illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: next_state = opcode[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMWB:  next_state = S_FETCH;
         S_EXECR, S_EXECI: begin
            if (funct3 == 3'b011) begin
               next_state  = S_TRAP;
               set_illegal = 1'b1;
            end else begin
               next_state = S_ALUWB;
            end
         end
         S_ALUWB: next_state = S_FETCH;
         S_BRANCH: begin
            if (funct3[2:1] == 2'b00) begin
               next_state = S_FETCH;
            end else begin
               next_state  = S_TRAP;
               set_illegal = 1'b1;
            end
         end
         S_JAL:   next_state = S_ALUWB;
         S_LUI:   next_state = S_ALUWB;
         default: next_state = S_TRAP;
      endcase
   end

   // Moore decode of the datapath controls. Strobes are computed here and
   // gated by reset below, so that they drop as soon as reset is asserted.
   always_comb begin
      mem_req_s   = 1'b0;
      mem_we_s    = 1'b0;
      ir_write_s  = 1'b0;
      pc_write_s  = 1'b0;
      reg_write_s = 1'b0;
      AdrSrc      = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ResultSrc   = 2'b00;
      ImmSrc      = IMM_I;
      ALUControl  = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_req_s  = 1'b1;
            ALUSrcB    = 2'b10;
            ResultSrc  = 2'b10;
            ir_write_s = mem_ready;
            pc_write_s = mem_ready;
         end
         S_DECODE: begin
            // ALUOut captures the branch target, or the jump target for JAL.
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            ImmSrc  = opcode[5] ? IMM_S : IMM_I;
         end
         S_MEMREAD: begin
            AdrSrc    = 1'b1;
            mem_req_s = 1'b1;
         end
         S_MEMWB: begin
            ResultSrc   = 2'b01;
            reg_write_s = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_req_s = 1'b1;
            mem_we_s  = 1'b1;
         end
         S_EXECR: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_decode(funct3, funct7b5, 1'b1);
         end
         S_EXECI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_decode(funct3, funct7b5, 1'b0);
         end
         S_ALUWB: reg_write_s = 1'b1;
         S_BRANCH: begin
            // beq takes on Zero, bne on !Zero. Illegal funct3 never writes PC.
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_write_s = (funct3[2:1] == 2'b00) && (Zero ^ funct3[0]);
         end
         S_JAL: begin
            ALUSrcA    = 2'b01;
            ALUSrcB    = 2'b10;
            pc_write_s = 1'b1;
         end
         S_LUI: begin
            ALUSrcA = 2'b11;
            ALUSrcB = 2'b01;
            ImmSrc  = IMM_U;
         end
         default: ;
      endcase
   end

   assign mem_req   = mem_req_s   & reset;
   assign mem_we    = mem_we_s    & reset;
   assign IRWrite   = ir_write_s  & reset;
   assign PCWrite   = pc_write_s  & reset;
   assign RegWrite  = reg_write_s & reset;
   assign state_out = state;

   // State, wait counter, sticky flags and performance counters. The wait
   // counter clears whenever no access is stalled. As a result, it is
   // already zero on entry to any memory state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= S_FETCH;
         wait_cnt      <= '0;
         illegal       <= 1'b0;
         mem_fault     <= 1'b0;
         cycle_count   <= '0;
         instret_count <= '0;
      end else begin
         state       <= next_state;
         cycle_count <= cycle_count + CNT_WIDTH'(1);
         if (mem_req_s && !mem_ready)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         else
            wait_cnt <= '0;
         if (set_illegal)
            illegal <= 1'b1;
         if (set_fault)
            mem_fault <= 1'b1;
         if (next_state == S_FETCH && state != S_FETCH && state != S_TRAP)
            instret_count <= instret_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb_riscv_multicycle_controller
// ------------------------------
// Directed testbench for riscv_multicycle_controller. The DUT is built
// with MEM_TIMEOUT=4. Inputs change on the falling edge, and outputs are
// sampled 1 ns later. Each test task drives its own scenario and checks
// against hand-computed values.

module tb_riscv_multicycle_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Instr = 32'h0;
   logic        Zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic        mem_req, mem_we, AdrSrc, IRWrite, PCWrite, RegWrite;
   logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
   logic [2:0]  ImmSrc;
   logic [3:0]  ALUControl, state_out;
   logic        illegal, mem_fault;
   logic [31:0] cycle_count, instret_count;

   int n_checks = 0;
   int n_fail   = 0;

   riscv_multicycle_controller #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .Instr(Instr), .Zero(Zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
      .state_out(state_out), .illegal(illegal), .mem_fault(mem_fault),
      .cycle_count(cycle_count), .instret_count(instret_count)
   );

   always #5 clk = ~clk;

   // Hold reset for two cycles, then release it on a falling edge. The
   // caller resumes in the first FETCH cycle after the release.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1; Zero = 1'b0; Instr = 32'h0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (state_out !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state_out); end
      n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req: got %b expected 0", mem_req); end
      n_checks++; if (IRWrite !== 1'b0 || PCWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_strobes: got IR=%b PC=%b expected 0 0", IRWrite, PCWrite); end
      n_checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instret_count); end
      n_checks++; if (illegal !== 1'b0 || mem_fault !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b%b expected 00", illegal, mem_fault); end
      n_checks++; if (ALUSrcB !== 2'b10 || ResultSrc !== 2'b10) begin n_fail++; $display("[TB] FAIL reset_decode: got B=%b R=%b expected 10 10", ALUSrcB, ResultSrc); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      n_checks++; if (mem_req !== 1'b1 || IRWrite !== 1'b1) begin n_fail++; $display("[TB] FAIL release_fetch: got req=%b ir=%b expected 1 1", mem_req, IRWrite); end
   endtask

   task automatic test_add();
      int exp_st[5] = '{0, 1, 6, 8, 0};
      bit exp_rw[5] = '{0, 0, 0, 1, 0};
      do_reset();
      Instr = 32'h002081B3;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++; if (state_out !== 4'(exp_st[i])) begin n_fail++; $display("[TB] FAIL add_state[%0d]: got %0d expected %0d", i, state_out, exp_st[i]); end
         n_checks++; if (RegWrite !== exp_rw[i]) begin n_fail++; $display("[TB] FAIL add_regwrite[%0d]: got %b expected %b", i, RegWrite, exp_rw[i]); end
         if (i == 2) begin
            n_checks++; if (ALUControl !== 4'b0000 || ALUSrcB !== 2'b00) begin n_fail++; $display("[TB] FAIL add_exec: got alu=%b B=%b expected 0000 00", ALUControl, ALUSrcB); end
         end
         if (i == 4) begin
            n_checks++; if (instret_count !== 32'd1 || cycle_count !== 32'd4) begin n_fail++; $display("[TB] FAIL add_counters: got %0d/%0d expected 1/4", instret_count, cycle_count); end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_lw();
      bit rdy[11]     = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
      int exp_st[11]  = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4};
      bit exp_req[11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
      do_reset();
      Instr = 32'h0000A183;
      for (int i = 0; i < 11; i++) begin
         mem_ready = rdy[i];
         #1;
         n_checks++; if (state_out !== 4'(exp_st[i])) begin n_fail++; $display("[TB] FAIL lw_state[%0d]: got %0d expected %0d", i, state_out, exp_st[i]); end
         n_checks++; if (mem_req !== exp_req[i]) begin n_fail++; $display("[TB] FAIL lw_mem_req[%0d]: got %b expected %b", i, mem_req, exp_req[i]); end
         if (i == 6) begin
            n_checks++; if (AdrSrc !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("[TB] FAIL lw_memread: got adr=%b we=%b expected 1 0", AdrSrc, mem_we); end
         end
         if (i == 10) begin
            n_checks++; if (RegWrite !== 1'b1 || ResultSrc !== 2'b01) begin n_fail++; $display("[TB] FAIL lw_memwb: got rw=%b rs=%b expected 1 01", RegWrite, ResultSrc); end
         end
         @(negedge clk);
      end
      mem_ready = 1'b1;
      #1;
      n_checks++; if (state_out !== 4'd0 || cycle_count !== 32'd11 || instret_count !== 32'd1) begin n_fail++; $display("[TB] FAIL lw_done: got st=%0d cyc=%0d ret=%0d expected 0 11 1", state_out, cycle_count, instret_count); end
      @(negedge clk);
   endtask

   task automatic test_branch();
      logic [31:0] ins[4] = '{32'h00208463, 32'h00208463, 32'h00209463, 32'h00209463};
      bit          z[4]   = '{1, 0, 1, 0};
      bit          pcw[4] = '{1, 0, 0, 1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         Instr = ins[i]; Zero = z[i]; mem_ready = 1'b1;
         #1;
         @(negedge clk);
         #1;
         n_checks++; if (ImmSrc !== 3'b010 || ALUSrcA !== 2'b01) begin n_fail++; $display("[TB] FAIL br_decode[%0d]: got imm=%b A=%b expected 010 01", i, ImmSrc, ALUSrcA); end
         @(negedge clk);
         #1;
         n_checks++; if (state_out !== 4'd9 || ALUControl !== 4'b0001) begin n_fail++; $display("[TB] FAIL br_state[%0d]: got st=%0d alu=%b expected 9 0001", i, state_out, ALUControl); end
         n_checks++; if (PCWrite !== pcw[i]) begin n_fail++; $display("[TB] FAIL br_pcwrite[%0d]: got %b expected %b", i, PCWrite, pcw[i]); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (state_out !== 4'd0 || instret_count !== 32'd4) begin n_fail++; $display("[TB] FAIL br_done: got st=%0d ret=%0d expected 0 4", state_out, instret_count); end
      @(negedge clk);
   endtask

   task automatic test_alu_decode();
      logic [31:0] ins[11] = '{32'h002081B3, 32'h402081B3, 32'h0020C1B3, 32'h0020F1B3,
                               32'h0020E1B3, 32'h002091B3, 32'h0020A1B3, 32'h0020D1B3,
                               32'h4020D1B3, 32'h40008193, 32'h4020D193};
      int          est[11] = '{6, 6, 6, 6, 6, 6, 6, 6, 6, 7, 7};
      logic [3:0]  alu[11] = '{4'b0000, 4'b0001, 4'b0100, 4'b0010, 4'b0011, 4'b0110,
                               4'b0101, 4'b0111, 4'b1000, 4'b0000, 4'b1000};
      do_reset();
      for (int i = 0; i < 11; i++) begin
         Instr = ins[i];
         @(negedge clk);
         @(negedge clk);
         #1;
         n_checks++; if (state_out !== 4'(est[i]) || ALUControl !== alu[i]) begin n_fail++; $display("[TB] FAIL alu[%0d]: got st=%0d alu=%b expected %0d %b", i, state_out, ALUControl, est[i], alu[i]); end
         @(negedge clk);
         #1;
         n_checks++; if (state_out !== 4'd8 || RegWrite !== 1'b1) begin n_fail++; $display("[TB] FAIL alu_wb[%0d]: got st=%0d rw=%b expected 8 1", i, state_out, RegWrite); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (instret_count !== 32'd11) begin n_fail++; $display("[TB] FAIL alu_instret: got %0d expected 11", instret_count); end
   endtask

   task automatic test_jal_lui();
      do_reset();
      Instr = 32'h008000EF;
      @(negedge clk); #1;
      n_checks++; if (ImmSrc !== 3'b011) begin n_fail++; $display("[TB] FAIL jal_decode_imm: got %b expected 011", ImmSrc); end
      @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd10 || PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin n_fail++; $display("[TB] FAIL jal_state: got st=%0d pcw=%b A=%b B=%b expected 10 1 01 10", state_out, PCWrite, ALUSrcA, ALUSrcB); end
      @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd8) begin n_fail++; $display("[TB] FAIL jal_wb: got %0d expected 8", state_out); end
      @(negedge clk);
      Instr = 32'h123451B7;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd11 || ALUSrcA !== 2'b11 || ImmSrc !== 3'b100 || PCWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL lui_state: got st=%0d A=%b imm=%b pcw=%b expected 11 11 100 0", state_out, ALUSrcA, ImmSrc, PCWrite); end
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd0 || instret_count !== 32'd2) begin n_fail++; $display("[TB] FAIL jal_lui_done: got st=%0d ret=%0d expected 0 2", state_out, instret_count); end
   endtask

   task automatic test_illegal();
      do_reset();
      Instr = 32'h0000007F;
      @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd1 || illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_decode: got st=%0d ill=%b expected 1 0", state_out, illegal); end
      @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd15 || illegal !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_trap: got st=%0d ill=%b expected 15 1", state_out, illegal); end
      repeat (5) @(negedge clk);
      #1;
      n_checks++; if (state_out !== 4'd15 || mem_req !== 1'b0 || RegWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL ill_hold: got st=%0d req=%b rw=%b expected 15 0 0", state_out, mem_req, RegWrite); end
      n_checks++; if (cycle_count !== 32'd7 || instret_count !== 32'd0) begin n_fail++; $display("[TB] FAIL ill_counters: got %0d/%0d expected 7/0", cycle_count, instret_count); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (state_out !== 4'd0 || illegal !== 1'b0 || cycle_count !== 32'd0) begin n_fail++; $display("[TB] FAIL ill_reset: got st=%0d ill=%b cyc=%0d expected 0 0 0", state_out, illegal, cycle_count); end
      // An R-type with funct3=011 traps from EXECR.
      do_reset();
      Instr = 32'h0020B1B3;
      repeat (3) @(negedge clk);
      #1;
      n_checks++; if (state_out !== 4'd15 || illegal !== 1'b1) begin n_fail++; $display("[TB] FAIL ill_funct3: got st=%0d ill=%b expected 15 1", state_out, illegal); end
   endtask

   task automatic test_timeout();
      do_reset();
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_checks++; if (state_out !== 4'd0 || mem_req !== 1'b1 || mem_fault !== 1'b0) begin n_fail++; $display("[TB] FAIL to_wait[%0d]: got st=%0d req=%b flt=%b expected 0 1 0", i, state_out, mem_req, mem_fault); end
         @(negedge clk);
      end
      #1;
      n_checks++; if (state_out !== 4'd15 || mem_fault !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL to_trap: got st=%0d flt=%b req=%b expected 15 1 0", state_out, mem_fault, mem_req); end
      n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL to_illegal: got %b expected 0", illegal); end
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_checks++; if (state_out !== 4'd15 || mem_fault !== 1'b1) begin n_fail++; $display("[TB] FAIL to_sticky: got st=%0d flt=%b expected 15 1", state_out, mem_fault); end
   endtask

   task automatic test_async_reset();
      do_reset();
      Instr = 32'h0020A023;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (state_out !== 4'd2 || ImmSrc !== 3'b001 || ALUSrcA !== 2'b10) begin n_fail++; $display("[TB] FAIL sw_memadr: got st=%0d imm=%b A=%b expected 2 001 10", state_out, ImmSrc, ALUSrcA); end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_checks++; if (state_out !== 4'd5 || mem_req !== 1'b1 || mem_we !== 1'b1 || AdrSrc !== 1'b1) begin n_fail++; $display("[TB] FAIL sw_memwrite: got st=%0d req=%b we=%b adr=%b expected 5 1 1 1", state_out, mem_req, mem_we, AdrSrc); end
      #2 reset = 1'b0;
      #1;
      n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || RegWrite !== 1'b0 || PCWrite !== 1'b0) begin n_fail++; $display("[TB] FAIL async_strobes: got req=%b we=%b rw=%b pcw=%b expected 0 0 0 0", mem_req, mem_we, RegWrite, PCWrite); end
      n_checks++; if (state_out !== 4'd0 || cycle_count !== 32'd0 || instret_count !== 32'd0) begin n_fail++; $display("[TB] FAIL async_state: got st=%0d cyc=%0d ret=%0d expected 0 0 0", state_out, cycle_count, instret_count); end
      @(negedge clk);
      reset = 1'b1; mem_ready = 1'b1;
   endtask

   // Safety net in case the run does not reach the summary line.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_branch();
      test_alu_decode();
      test_jal_lui();
      test_illegal();
      test_timeout();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_controller.md
Name: riscv_multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle core's Controller.
- Drives a shared-memory multi-cycle RV32I datapath, one instruction per state sequence, through a variable-latency memory req/ready handshake.
- Adds the following, none of which the single-cycle controller has: memory timeout detection, illegal-opcode trap, and cycle/instret performance counters readable via the debug path.

Parameters:
- MEM_TIMEOUT, 16: max wait cycles per memory access before fault; 0 disables timeout.
- CNT_WIDTH, 32: width of cycle_count and instret_count.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Instr  in  32  instruction register contents (valid from DECODE onward).
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  access is a write.
- AdrSrc  out  1  0=PC, 1=ALUOut.
- IRWrite  out  1  load IR and OldPC.
- PCWrite  out  1  load PC from Result.
- RegWrite  out  1  register file write.
- ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1, 11=zero.
- ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=mem data, 10=ALU result.
- ImmSrc  out  3  000=I, 001=S, 010=B, 011=J, 100=U.
- ALUControl  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sll, 0111 srl, 1000 sra.
- state_out  out  4  current state encoding, for debug.
- illegal  out  1  sticky: illegal opcode trapped.
- mem_fault  out  1  sticky: memory timeout trapped.
- cycle_count  out  CNT_WIDTH  cycles since reset release.
- instret_count  out  CNT_WIDTH  retired instructions.

Behaviour:
- Reset (reset=0, async):
  - State returns to FETCH (0).
  - Counters, illegal and mem_fault clear to 0.
  - mem_req, mem_we, PCWrite, IRWrite and RegWrite are forced to 0 for as long as reset=0.
  - All other outputs decode from FETCH.
- All outputs are Moore outputs: combinational from state and Instr.
- Exception: strobes gated by mem_ready or Zero, as noted below.
- State encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, LUI 11, TRAP 15.
- FETCH: AdrSrc=0, mem_req=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite are set equal to mem_ready.
  - Stay in FETCH until mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ImmSrc=B, add (precomputes the branch target). Next state by opcode:
  - 0000011 -> MEMADR
  - 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL; in this state ImmSrc=J, so ALUOut holds the jump target
  - 0110111 -> LUI
  - any other opcode -> TRAP with illegal=1
- MEMADR: ALUSrcA=10, ALUSrcB=01, add; ImmSrc=I for loads, S for stores. Loads go to MEMREAD, stores to MEMWRITE.
- MEMREAD: AdrSrc=1, mem_req=1; wait for mem_ready, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: AdrSrc=1, mem_req=1, mem_we=1; wait for mem_ready, then FETCH.
- EXECR / EXECI: ALUSrcA=10; ALUSrcB=00 (EXECR) or 01 (EXECI); next state ALUWB. ALUControl decode from funct3:
  - 000: add, or sub if R-type and funct7[5]=1
  - 001: sll
  - 010: slt
  - 100: xor
  - 101: srl, or sra if funct7[5]=1
  - 110: or
  - 111: and
  - funct3=011 -> TRAP with illegal=1
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00; PCWrite = Zero XOR funct3[0] (beq/bne). Next state FETCH. funct3 other than 000/001 is illegal.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ALUWB (rd=OldPC+4).
- LUI: ALUSrcA=11, ALUSrcB=01, ImmSrc=U, add, then ALUWB.
- Timeout:
  - A wait counter clears on entry to any memory state.
  - It increments each cycle mem_req=1 and mem_ready=0.
  - If it reaches MEM_TIMEOUT (MEM_TIMEOUT != 0), go to TRAP and set mem_fault=1.
  - mem_ready in the same cycle as the timeout wins: the access completes normally.
- TRAP: all strobes 0; held until reset. Flags are sticky.
- cycle_count: increments every cycle out of reset, wraps at 2^CNT_WIDTH.
- instret_count: increments on every transition into FETCH from a non-FETCH, non-TRAP state; wraps.
- Zero-wait memory (mem_ready=1 in the request cycle) is legal: no extra cycle is spent.

Test Plan:
- Reset released, mem_ready tied 1, add x3,x1,x2 (0x002081B3) -> states 0,1,6,8,0; RegWrite=1 in ALUWB only; ALUControl=0000; instret_count=1 after 4 cycles.
- lw (0x0000A183) with mem_ready delayed 3 cycles in both FETCH and MEMREAD -> mem_req held 4 cycles each; total 11 cycles; RegWrite=1 in MEMWB with ResultSrc=01.
- beq (0x00208463) with Zero=1 then Zero=0 on a second run -> PCWrite=1 in BRANCH for the first run, 0 for the second; bne inverts.
- Opcode 0x0000007F -> TRAP after DECODE, illegal=1, state_out=15; counters keep cycling; only reset (reset=0) returns to FETCH.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP at the 4th wait cycle, mem_fault=1, mem_req=0 thereafter.
- Assert reset=0 mid-MEMWRITE -> mem_req, mem_we, RegWrite and PCWrite drop immediately (asynchronously); state 0; counters 0.
